// File: rtl/tree_pkg.sv
// Shared types for the message-hierarchy tree: node word layout, field accessors,
// error codes and the build sequencer's state encoding.
package tree_pkg;

    localparam int IDENTIFIER_SIZE     = 8;
    localparam int NODE_ADDR_SIZE      = 8;
    localparam int MAX_NODES_PER_LEVEL = 4;
    localparam int NUM_MSG_HIERARCHY   = 4;
    localparam int NUM_NODES_DFLT      = 256;

    localparam int NODE_SIZE = IDENTIFIER_SIZE + NODE_ADDR_SIZE * (MAX_NODES_PER_LEVEL + 1);
    localparam int PATH_W    = NUM_MSG_HIERARCHY * IDENTIFIER_SIZE;
    localparam int SLOT_W    = $clog2(MAX_NODES_PER_LEVEL + 1);
    localparam int LVL_W     = $clog2(NUM_MSG_HIERARCHY + 1);

    typedef logic [NODE_SIZE-1:0]       node_t;
    typedef logic [NODE_ADDR_SIZE-1:0]  addr_t;
    typedef logic [IDENTIFIER_SIZE-1:0] id_t;

    typedef enum logic [1:0] {
        ERR_OK         = 2'b00,
        ERR_NOT_FOUND  = 2'b01,
        ERR_TREE_FULL  = 2'b10,
        ERR_LEVEL_FULL = 2'b11
    } err_e;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_RD_NODE,
        S_CAP_NODE,
        S_RD_CHILD,
        S_CAP_CHILD,
        S_WR_NEW,
        S_WR_PARENT,
        S_RESP
    } state_e;

    function automatic id_t node_id(input node_t n);
        return n[NODE_SIZE-1 -: IDENTIFIER_SIZE];
    endfunction

    function automatic addr_t node_parent(input node_t n);
        return n[MAX_NODES_PER_LEVEL*NODE_ADDR_SIZE +: NODE_ADDR_SIZE];
    endfunction

    function automatic addr_t node_child(input node_t n, input logic [SLOT_W-1:0] k);
        return n[k*NODE_ADDR_SIZE +: NODE_ADDR_SIZE];
    endfunction

    function automatic node_t set_child(input node_t n, input logic [SLOT_W-1:0] k, input addr_t a);
        node_t r;
        r = n;
        r[k*NODE_ADDR_SIZE +: NODE_ADDR_SIZE] = a;
        return r;
    endfunction

    // Fresh node: identifier and parent link set, every child slot empty.
    function automatic node_t make_node(input id_t id, input addr_t parent);
        node_t r;
        r = '0;
        r[NODE_SIZE-1 -: IDENTIFIER_SIZE] = id;
        r[MAX_NODES_PER_LEVEL*NODE_ADDR_SIZE +: NODE_ADDR_SIZE] = parent;
        return r;
    endfunction

endpackage

// File: rtl/tree_build_ctrl_if.sv
// Path request / result handshake between the decoder front end and the tree sequencer.
interface tree_build_ctrl_if;
    import tree_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_insert;
    logic [PATH_W-1:0] req_path;
    logic              rsp_valid;
    logic              rsp_ready;
    addr_t             rsp_addr;
    logic [1:0]        rsp_err;

    modport master (
        output req_valid, req_insert, req_path, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_insert, req_path, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_err
    );

endinterface

// File: rtl/tree_node_ram.sv
// Single-port node memory with a registered read port (data valid the cycle after en).
module tree_node_ram
    import tree_pkg::*;
#(
    parameter int DEPTH = NUM_NODES_DFLT
) (
    input  logic  clk,
    input  logic  en,
    input  logic  we,
    input  addr_t addr,
    input  node_t wdata,
    output node_t rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    node_t            ram_q [DEPTH];
    node_t            rdata_q;
    logic [IDX_W-1:0] idx;

    assign idx   = addr[IDX_W-1:0];
    assign rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                ram_q[idx] <= wdata;
            end else begin
                rdata_q <= ram_q[idx];
            end
        end
    end

endmodule

// File: rtl/tree_build_ctrl.sv
// Run-time tree sequencer: clears node RAM, then walks one identifier path per request,
// either looking it up or inserting any missing nodes, and returns the deepest node address.
module tree_build_ctrl
    import tree_pkg::*;
#(
    parameter int NUM_NODES = NUM_NODES_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    tree_build_ctrl_if.slave bus,
    output logic             mem_en,
    output logic             mem_we,
    output addr_t            mem_addr,
    output node_t            mem_wdata,
    input  node_t            mem_rdata,
    output logic             init_done
);

    localparam int                CNT_W     = NODE_ADDR_SIZE + 1;
    localparam logic [CNT_W-1:0]  NODES_END = CNT_W'(NUM_NODES);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(NUM_MSG_HIERARCHY);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_NODES_PER_LEVEL - 1);
    localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(MAX_NODES_PER_LEVEL);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]  next_addr_q, next_addr_d;
    addr_t             cur_q, cur_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PATH_W-1:0] path_q, path_d;
    logic              insert_q, insert_d;
    node_t             pnode_q, pnode_d;
    addr_t             rsp_addr_q, rsp_addr_d;
    err_e              rsp_err_q, rsp_err_d;
    logic              init_done_q, init_done_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    addr_t             mem_addr_q, mem_addr_d;
    node_t             mem_wdata_q, mem_wdata_d;

    id_t               cur_id;
    logic              miss;
    logic [SLOT_W-1:0] miss_slot;

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign mem_en        = mem_en_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign init_done     = init_done_q;

    always_comb begin
        cur_id = '0;
        for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
            if (level_q == LVL_W'(i)) begin
                cur_id = path_q[i*IDENTIFIER_SIZE +: IDENTIFIER_SIZE];
            end
        end
    end

    // RAM strobes are registered, so each one is issued on the transition into the
    // state that owns the access; read data then lands in the following state.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        next_addr_d = next_addr_q;
        cur_d       = cur_q;
        level_d     = level_q;
        slot_d      = slot_q;
        path_d      = path_q;
        insert_d    = insert_q;
        pnode_d     = pnode_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        init_done_d = init_done_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        miss        = 1'b0;
        miss_slot   = '0;

        unique case (state_q)
            S_INIT: begin
                if (init_cnt_q == NODES_END) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    next_addr_d = CNT_W'(1);
                end else begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = init_cnt_q[NODE_ADDR_SIZE-1:0];
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    path_d   = bus.req_path;
                    insert_d = bus.req_insert;
                    cur_d    = '0;
                    level_d  = '0;
                    state_d  = S_RD_NODE;
                    mem_en_d = 1'b1;
                end
            end
            S_RD_NODE: begin
                if (level_q == LVL_MAX || cur_id == '0) begin
                    state_d    = S_RESP;
                    rsp_err_d  = ERR_OK;
                    rsp_addr_d = cur_q;
                end else begin
                    state_d = S_CAP_NODE;
                end
            end
            S_CAP_NODE: begin
                pnode_d = mem_rdata;
                slot_d  = '0;
                if (node_child(mem_rdata, '0) != '0) begin
                    state_d    = S_RD_CHILD;
                    mem_en_d   = 1'b1;
                    mem_addr_d = node_child(mem_rdata, '0);
                end else begin
                    miss      = 1'b1;
                    miss_slot = '0;
                end
            end
            S_RD_CHILD: begin
                state_d = S_CAP_CHILD;
            end
            S_CAP_CHILD: begin
                if (node_id(mem_rdata) == cur_id) begin
                    cur_d      = node_child(pnode_q, slot_q);
                    level_d    = level_q + 1'b1;
                    state_d    = S_RD_NODE;
                    mem_en_d   = 1'b1;
                    mem_addr_d = cur_d;
                end else if (slot_q == SLOT_LAST) begin
                    miss      = 1'b1;
                    miss_slot = SLOT_FULL;
                end else if (node_child(pnode_q, slot_q + 1'b1) == '0) begin
                    miss      = 1'b1;
                    miss_slot = slot_q + 1'b1;
                end else begin
                    slot_d     = slot_q + 1'b1;
                    state_d    = S_RD_CHILD;
                    mem_en_d   = 1'b1;
                    mem_addr_d = node_child(pnode_q, slot_q + 1'b1);
                end
            end
            S_WR_NEW: begin
                state_d     = S_WR_PARENT;
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = cur_q;
                mem_wdata_d = set_child(pnode_q, slot_q, next_addr_q[NODE_ADDR_SIZE-1:0]);
            end
            S_WR_PARENT: begin
                cur_d       = next_addr_q[NODE_ADDR_SIZE-1:0];
                next_addr_d = next_addr_q + 1'b1;
                level_d     = level_q + 1'b1;
                state_d     = S_RD_NODE;
                mem_en_d    = 1'b1;
                mem_addr_d  = cur_d;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase

        // Scan ended without a match; miss_slot is the first empty slot (or FULL).
        if (miss) begin
            if (!insert_q) begin
                state_d    = S_RESP;
                rsp_err_d  = ERR_NOT_FOUND;
                rsp_addr_d = cur_q;
            end else if (next_addr_q == NODES_END) begin
                state_d    = S_RESP;
                rsp_err_d  = ERR_TREE_FULL;
                rsp_addr_d = cur_q;
            end else if (miss_slot == SLOT_FULL) begin
                state_d    = S_RESP;
                rsp_err_d  = ERR_LEVEL_FULL;
                rsp_addr_d = cur_q;
            end else begin
                slot_d      = miss_slot;
                state_d     = S_WR_NEW;
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = next_addr_q[NODE_ADDR_SIZE-1:0];
                mem_wdata_d = make_node(cur_id, cur_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            next_addr_q <= '0;
            cur_q       <= '0;
            level_q     <= '0;
            slot_q      <= '0;
            path_q      <= '0;
            insert_q    <= 1'b0;
            pnode_q     <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= ERR_OK;
            init_done_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            next_addr_q <= next_addr_d;
            cur_q       <= cur_d;
            level_q     <= level_d;
            slot_q      <= slot_d;
            path_q      <= path_d;
            insert_q    <= insert_d;
            pnode_q     <= pnode_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
            init_done_q <= init_done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_tree_build_ctrl.sv
// Directed bench for tree_build_ctrl with a 16-entry node RAM.
module tb_tree_build_ctrl;
    import tree_pkg::*;

    localparam int NN = 16;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  mem_en, mem_we, init_done;
    addr_t mem_addr;
    node_t mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    tree_build_ctrl_if bus();

    tree_build_ctrl #(.NUM_NODES(NN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    tree_node_ram #(.DEPTH(NN)) u_ram (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] p4(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Expected node word: id, parent, children 0..3.
    function automatic node_t nd(input logic [7:0] id, par, c0, c1, c2, c3);
        return {id, par, c3, c2, c1, c0};
    endfunction

    task automatic ram_all_zero(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < NN; i++) begin
            if (u_ram.ram_q[i] !== '0) nz++;
        end
        check(tag, nz, 0);
    endtask

    task automatic run_req(input string tag, input logic ins, input logic [31:0] path,
                           input int hold, input logic [7:0] exp_addr, input logic [1:0] exp_err,
                           input int exp_lat, input int exp_wr);
        int budget, lat, wr;
        logic [7:0] addr;
        logic [1:0] err;
        budget = 0;
        while (!bus.req_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check($sformatf("%s_ready", tag), bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_insert = ins;
        bus.req_path   = path;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        wr  = 0;
        while (!bus.rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (mem_en && mem_we) wr++;
        end
        check($sformatf("%s_rsp_valid", tag), bus.rsp_valid, 1'b1);
        addr = bus.rsp_addr;
        err  = bus.rsp_err;
        $display("req %s ins=%0d path=%h -> addr=%0d err=%0d lat=%0d writes=%0d",
                 tag, ins, path, addr, err, lat, wr);
        check($sformatf("%s_addr", tag), addr, exp_addr);
        check($sformatf("%s_err", tag), err, exp_err);
        if (exp_lat >= 0) check($sformatf("%s_lat", tag), lat, exp_lat);
        if (exp_wr >= 0) check($sformatf("%s_writes", tag), wr, exp_wr);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("%s_hold_valid", tag), bus.rsp_valid, 1'b1);
            check($sformatf("%s_hold_addr", tag), bus.rsp_addr, exp_addr);
            check($sformatf("%s_hold_err", tag), bus.rsp_err, exp_err);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check($sformatf("%s_idle_after", tag), bus.req_ready, 1'b1);
        check($sformatf("%s_valid_drop", tag), bus.rsp_valid, 1'b0);
    endtask

    initial begin
        int t;
        bus.req_valid  = 1'b0;
        bus.req_insert = 1'b0;
        bus.req_path   = '0;
        bus.rsp_ready  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_addr", bus.rsp_addr, 8'd0);
        check("rst_rsp_err", bus.rsp_err, 2'd0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 8'd0);
        check("rst_mem_wdata", mem_wdata, 48'd0);
        check("rst_init_done", init_done, 1'b0);

        // Init sweep: ready on the 17th edge after release
        rst_n = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("init_ready_c16", bus.req_ready, 1'b0);
        check("init_done_c16", init_done, 1'b0);
        @(posedge clk); #1;
        check("init_ready_c17", bus.req_ready, 1'b1);
        check("init_done_c17", init_done, 1'b1);
        ram_all_zero("init_ram_zero");

        // Insert, lookup, miss, re-insert
        run_req("ins57", 1'b1, p4(5, 7, 0, 0), 0, 8'd2, 2'd0, 9, 4);
        check("node0", u_ram.ram_q[0], nd(0, 0, 1, 0, 0, 0));
        check("node1", u_ram.ram_q[1], nd(5, 0, 2, 0, 0, 0));
        check("node2", u_ram.ram_q[2], nd(7, 1, 0, 0, 0, 0));
        run_req("lk57", 1'b0, p4(5, 7, 0, 0), 0, 8'd2, 2'd0, 9, 0);
        run_req("lk59", 1'b0, p4(5, 9, 0, 0), 0, 8'd1, 2'd1, -1, 0);
        run_req("reins57", 1'b1, p4(5, 7, 0, 0), 0, 8'd2, 2'd0, 9, 0);

        // Fill node2's four slots, then overflow it
        run_req("ins571", 1'b1, p4(5, 7, 1, 0), 0, 8'd3, 2'd0, 13, 2);
        run_req("ins572", 1'b1, p4(5, 7, 2, 0), 0, 8'd4, 2'd0, 15, 2);
        run_req("ins573", 1'b1, p4(5, 7, 3, 0), 0, 8'd5, 2'd0, -1, 2);
        run_req("ins574", 1'b1, p4(5, 7, 4, 0), 0, 8'd6, 2'd0, -1, 2);
        run_req("ins576", 1'b1, p4(5, 7, 6, 0), 0, 8'd2, 2'd3, -1, 0);
        check("node2_full", u_ram.ram_q[2], nd(7, 1, 3, 4, 5, 6));

        // Fill the RAM to next_addr == 16
        run_req("ins9123", 1'b1, p4(9, 1, 2, 3), 0, 8'd10, 2'd0, 19, 8);
        run_req("ins9124", 1'b1, p4(9, 1, 2, 4), 0, 8'd11, 2'd0, -1, 2);
        run_req("ins9125", 1'b1, p4(9, 1, 2, 5), 0, 8'd12, 2'd0, -1, 2);
        run_req("ins9126", 1'b1, p4(9, 1, 2, 6), 0, 8'd13, 2'd0, -1, 2);
        run_req("ins913", 1'b1, p4(9, 1, 3, 0), 0, 8'd14, 2'd0, -1, 2);
        run_req("ins914", 1'b1, p4(9, 1, 4, 0), 0, 8'd15, 2'd0, -1, 2);
        check("node0_two", u_ram.ram_q[0], nd(0, 0, 1, 7, 0, 0));
        check("node8", u_ram.ram_q[8], nd(1, 7, 9, 14, 15, 0));
        run_req("ins915", 1'b1, p4(9, 1, 5, 0), 0, 8'd8, 2'd2, -1, 0);
        run_req("ins8", 1'b1, p4(8, 0, 0, 0), 0, 8'd0, 2'd2, -1, 0);

        // Full-depth lookup with the result held for 10 cycles
        run_req("lk9126", 1'b0, p4(9, 1, 2, 6), 10, 8'd13, 2'd0, 25, 0);
        run_req("lk574", 1'b0, p4(5, 7, 4, 0), 0, 8'd6, 2'd0, -1, 0);

        // Reset pulsed in the middle of a walk
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_insert = 1'b1;
        bus.req_path   = p4(9, 1, 2, 6);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", bus.req_ready, 1'b0);
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        check("midrst_mem_en", mem_en, 1'b0);
        check("midrst_init_done", init_done, 1'b0);
        check("midrst_rsp_addr", bus.rsp_addr, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (!bus.req_ready && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("reinit_ready", bus.req_ready, 1'b1);
        check("reinit_cycles", t, 17);
        ram_all_zero("reinit_ram_zero");
        run_req("lk5_after", 1'b0, p4(5, 0, 0, 0), 0, 8'd0, 2'd1, -1, 0);
        run_req("ins5_after", 1'b1, p4(5, 0, 0, 0), 0, 8'd1, 2'd0, 5, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
